data_cache: RTL

Direct-mapped, write-back, write-allocate data cache for the MEM stage, directly downstream of the EX/MEM pipeline register. It consumes the registered ALU result as the address, the store operand, and the memory read/write controls. It returns load data to MEM/WB and drives `dcache_stall`, which freezes the upstream pipeline registers until a miss is serviced. Misses are serviced over a single-word request/ready handshake to backing data memory.

---
 rtl/data_cache.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// One 32-bit word per line; misses are serviced through a single-word
// request/ready handshake to backing memory (write-back of a dirty victim,
// then refill).
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   addr            byte address from EX/MEM (bits [1:0] ignored)
//   wdata, wstrb    lane-aligned store data and byte enables
//   mem_read/write  load/store request for this cycle
//   rdata           load data (valid when mem_read & ~dcache_stall)
//   dcache_stall    freezes the upstream pipeline while a miss is serviced
//   dmem_*          backing-memory handshake (req/we/addr/wdata out, rdata/ready in)
module data_cache #(
  parameter int unsigned INDEX_WID = 6,
  parameter int unsigned TAG_WID   = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic        dcache_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready
);

  localparam int unsigned NumLines = 2 ** INDEX_WID;

  typedef enum logic [1:0] {StIdle, StWriteback, StRefill} state_e;

  state_e state_q, state_d;

  logic [31:0]         data_q [NumLines];
  logic [TAG_WID-1:0]  tag_q  [NumLines];
  logic [NumLines-1:0] valid_q, valid_d;
  logic [NumLines-1:0] dirty_q, dirty_d;

  logic [INDEX_WID-1:0] idx;
  logic [TAG_WID-1:0]   tag;
  logic [31:0]          line_data;
  logic [TAG_WID-1:0]   line_tag;
  logic                 hit;
  logic                 access;
  logic [31:0]          store_merged;
  logic                 line_we;
  logic [31:0]          line_wdata;
  logic                 tag_we;

  // Byte offset is irrelevant for a word-organised cache.
  logic unused_addr;
  assign unused_addr = ^addr[1:0];

  assign idx       = addr[INDEX_WID+1:2];
  assign tag       = addr[31:INDEX_WID+2];
  assign line_data = data_q[idx];
  assign line_tag  = tag_q[idx];
  assign hit       = valid_q[idx] & (line_tag == tag);
  assign access    = mem_read | mem_write;

  assign rdata        = line_data;
  assign dcache_stall = (state_q != StIdle) | (access & ~hit);

  always_comb begin
    store_merged = line_data;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) store_merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    line_we    = 1'b0;
    line_wdata = store_merged;
    tag_we     = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = 32'h0;
    dmem_wdata = 32'h0;

    unique case (state_q)
      StIdle: begin
        if (access) begin
          if (hit) begin
            // Re-applying the same merge under an external freeze is harmless.
            if (mem_write) begin
              line_we      = 1'b1;
              dirty_d[idx] = 1'b1;
            end
          end else if (valid_q[idx] && dirty_q[idx]) begin
            state_d = StWriteback;
          end else begin
            state_d = StRefill;
          end
        end
      end
      StWriteback: begin
        dmem_req   = 1'b1;
        dmem_we    = 1'b1;
        dmem_addr  = {line_tag, idx, 2'b00};
        dmem_wdata = line_data;
        if (dmem_ready) begin
          dirty_d[idx] = 1'b0;
          state_d      = StRefill;
        end
      end
      StRefill: begin
        dmem_req  = 1'b1;
        dmem_addr = {addr[31:2], 2'b00};
        if (dmem_ready) begin
          line_we      = 1'b1;
          line_wdata   = dmem_rdata;
          tag_we       = 1'b1;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Data and tag arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (!rst && line_we) data_q[idx] <= line_wdata;
    if (!rst && tag_we)  tag_q[idx]  <= tag;
  end

endmodule
